nibble_accum: RTL and testbench
===============================

# nibble_accum

Operand-side sequencer for the four-operand nibble adder datapath. It accepts 4-bit operands one per handshake and accumulates a fixed number of them. It then presents the low nibble sum plus a carry/overflow flag, in the same `oa`/`oco` format the adder produces. The block sits upstream of the result display and replaces the parallel `ia*/ib*/ic*/id*` operand buses with a streamed, back-pressured interface.

## Interface
Parameters:
- `OPS`, default 4: operands per result; legal range 2..8.
- `W`, default 4: operand width in bits.

Ports:
- `clk` in 1: single clock, rising-edge.
- `res` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand offered.
- `in_ready` out 1: block accepts an operand this cycle.
- `in_data` in W: operand value, unsigned.
- `in_flush` in 1: synchronous abort of the current accumulation.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `out_sum` out W: low W bits of the total (`oa` equivalent).
- `out_co` out 1: set when the total is ≥ 2^W (`oco` equivalent).
- `out_full` out SW: complete total, where SW = W + clog2(OPS); 6 bits at defaults.
- `res_cnt` out 8: count of delivered results; wraps 255→0.

## Operation
- FSM states:
  - `COLLECT`: accumulating operands.
  - `DONE`: holding the result.
- Operand acceptance:
  - An operand is accepted when `in_valid && in_ready`.
  - `in_ready` = (state == `COLLECT`) && !`res`. It is combinational and does not depend on `in_valid`.
- In `COLLECT`, each accepted operand updates `acc <= acc + in_data` and `cnt <= cnt + 1`.
- On acceptance of operand number OPS (`cnt == OPS-1`):
  - Latch the final total, including the current `in_data`, into the output registers.
  - Go to `DONE`.
  - Clear `cnt` and `acc`.
- In `DONE`:
  - `out_valid` = 1 and `in_ready` = 0.
  - `out_sum`, `out_co` and `out_full` stay stable until the output handshake.
  - On `out_valid && out_ready`: go to `COLLECT`, deassert `out_valid`, and increment `res_cnt`.
- Arithmetic:
  - `acc` is SW bits wide and unsigned; it cannot overflow because OPS·(2^W−1) < 2^SW.
  - `out_sum` = `full[W-1:0]`.
  - `out_co` = |`full[SW-1:W]`.
- `in_flush`:
  - In any state, it clears `acc` and `cnt`, forces `COLLECT`, and clears `out_valid`.
  - A pending result is discarded and `res_cnt` is not incremented.
  - Priority: `res` > `in_flush` > handshakes.
  - An operand offered in a flush cycle is not accepted; `in_ready` is still 1 in that cycle.
- Reset values:
  - state `COLLECT`, `acc` 0, `cnt` 0, `res_cnt` 0.
  - `out_valid` 0, `out_sum` 0, `out_co` 0, `out_full` 0.
  - `in_ready` is 0 while `res` = 1 and 1 on the first cycle after release.

## Timing
- Latency: if the last operand is accepted at edge N, `out_valid` and valid data are visible after edge N, in cycle N+1.
- No bubble between operands: back-to-back `in_valid` accepts one operand per cycle.
- Minimum period per result is OPS+1 cycles: OPS accepts plus one output handshake cycle.
- The output handshake at edge M makes `in_ready` = 1 in cycle M+1. There is no same-cycle pass-through from out to in.
- `out_*` must not change while `out_valid` && !`out_ready`.
- Reset mid-accumulation or mid-hold takes effect at the next edge. Partial sums are lost.
- `res_cnt` updates on the same edge as the output handshake.

## Structure
- Shared package `nibble_accum_pkg` contains:
  - the state enum (`COLLECT`, `DONE`);
  - the localparam function for SW (`W + $clog2(OPS)`);
  - the default constants `OPS_DEF` = 4 and `W_DEF` = 4.
- No sub-module. The FSM, accumulator and output register live in one module of about 150 lines.

## Test plan
- Basic sum: reset, then stream operands 1, 2, 3, 4 with `out_ready` = 1. Expected `out_full` = 6'h0A, `out_sum` = 4'hA, `out_co` = 0; `out_valid` high exactly 1 cycle after the 4th accept; `res_cnt` = 1.
- Maximum total: stream 15, 15, 15, 15. Expected `out_full` = 6'h3C, `out_sum` = 4'hC, `out_co` = 1.
- Backpressure:
  - Complete 2, 2, 2, 2, then hold `out_ready` = 0 for 5 cycles while `in_valid` = 1 with data 7.
  - Expected: `out_sum` stays 4'h8 and `in_ready` = 0 throughout.
  - After `out_ready` is raised, the next result starts from 7 as its first operand.
- Flush:
  - Accept 9 and 9, assert `in_flush` for 1 cycle, then stream 4, 4, 4, 4.
  - Expected `out_full` = 6'h10, `out_sum` = 0, `out_co` = 1, `res_cnt` += 1.
  - Separately, flush while in `DONE`: `out_valid` drops next cycle and `res_cnt` is unchanged.
- Reset mid-operation:
  - Accept 3 operands, assert `res` for 1 cycle, then stream 1, 1, 1, 1.
  - Expected: all outputs 0 during reset, then `out_full` = 4, with no contribution from pre-reset operands.
- Counter wrap: deliver 256 results of 0, 0, 0, 0. Expected `res_cnt` = 0 after the 256th handshake and 1 after the 257th.

Source files
------------

// File: rtl/nibble_accum_pkg.sv
// nibble_accum_pkg: shared types and constants for the streamed nibble accumulator.
// Holds the FSM state enum, default sizes and the total-width helper.
package nibble_accum_pkg;

    localparam int OPS_DEF = 4;
    localparam int W_DEF   = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    // Width needed to hold OPS operands of W bits without overflow.
    function automatic int sum_width(input int w, input int ops);
        return w + $clog2(ops);
    endfunction

endpackage

// File: rtl/nibble_accum.sv
// nibble_accum: accumulates OPS streamed W-bit operands and holds the total.
// Ports: clk, res (sync high reset), in_valid/in_ready/in_data/in_flush,
//        out_valid/out_ready, out_sum, out_co, out_full, res_cnt.
module nibble_accum
    import nibble_accum_pkg::*;
#(
    parameter  int OPS = OPS_DEF,
    parameter  int W   = W_DEF,
    localparam int SW  = sum_width(W, OPS)
) (
    input  logic          clk,
    input  logic          res,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic          out_co,
    output logic [SW-1:0] out_full,
    output logic [7:0]    res_cnt
);

    localparam int CW = $clog2(OPS);
    localparam logic [CW-1:0] LAST = CW'(OPS - 1);

    state_t        state;
    logic [SW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sum_next;

    // Ready is independent of in_valid; a flush cycle still shows ready.
    assign in_ready = (state == COLLECT) && !res;
    assign sum_next = acc + SW'(in_data);

    assign out_sum = out_full[W-1:0];
    assign out_co  = |out_full[SW-1:W];

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= COLLECT;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_full  <= '0;
            res_cnt   <= '0;
        end else if (in_flush) begin
            // Drop partial sum and any held result; res_cnt untouched.
            state     <= COLLECT;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (in_valid) begin
                        if (cnt == LAST) begin
                            out_full  <= sum_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                            acc       <= '0;
                            cnt       <= '0;
                        end else begin
                            acc <= sum_next;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= COLLECT;
                        out_valid <= 1'b0;
                        res_cnt   <= res_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_accum.sv
// tb_nibble_accum: directed and random checks of nibble_accum against
// a queue-based reference model of operand collection and result delivery.
module tb_nibble_accum;

    localparam int OPS = 4;
    localparam int W   = 4;
    localparam int SW  = W + $clog2(OPS);

    logic          clk = 1'b0;
    logic          res = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_co;
    logic [SW-1:0] out_full;
    logic [7:0]    res_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int q[$];
    bit m_pending = 0;
    int m_full = 0;
    int m_rescnt = 0;

    nibble_accum #(.OPS(OPS), .W(W)) dut (
        .clk      (clk),
        .res      (res),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_flush (in_flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_co   (out_co),
        .out_full (out_full),
        .res_cnt  (res_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check ready, clock, update model, check outputs.
    task automatic step(input bit v, input int d, input bit fl,
                        input bit ordy, input bit rs);
        int total;
        in_valid  = v;
        in_data   = W'(d);
        in_flush  = fl;
        out_ready = ordy;
        res       = rs;
        #1;
        check("in_ready", 32'(in_ready), 32'(!rs && !m_pending));
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_pending = 0;
            m_full = 0;
            m_rescnt = 0;
        end else if (fl) begin
            q.delete();
            m_pending = 0;
        end else if (!m_pending) begin
            if (v) begin
                q.push_back(d);
                if (q.size() == OPS) begin
                    total = 0;
                    foreach (q[i]) total += q[i];
                    m_full = total;
                    m_pending = 1;
                    q.delete();
                end
            end
        end else if (ordy) begin
            m_pending = 0;
            m_rescnt = (m_rescnt + 1) % 256;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_pending));
        check("out_full", 32'(out_full), 32'(m_full));
        check("out_sum", 32'(out_sum), 32'(m_full % (1 << W)));
        check("out_co", 32'(out_co), 32'(m_full >= (1 << W)));
        check("res_cnt", 32'(res_cnt), 32'(m_rescnt));
    endtask

    task automatic feed(input int a, input int b, input int c, input int d);
        step(1, a, 0, 1, 0);
        step(1, b, 0, 1, 0);
        step(1, c, 0, 1, 0);
        step(1, d, 0, 1, 0);
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("rst_full", 32'(out_full), 32'h0);
        check("rst_cnt", 32'(res_cnt), 32'h0);

        // Basic sum 1+2+3+4
        feed(1, 2, 3, 4);
        check("basic_valid", 32'(out_valid), 32'h1);
        check("basic_full", 32'(out_full), 32'h0A);
        check("basic_sum", 32'(out_sum), 32'hA);
        check("basic_co", 32'(out_co), 32'h0);
        step(0, 0, 0, 1, 0);
        check("basic_rescnt", 32'(res_cnt), 32'h1);

        // Maximum total
        feed(15, 15, 15, 15);
        check("max_full", 32'(out_full), 32'h3C);
        check("max_sum", 32'(out_sum), 32'hC);
        check("max_co", 32'(out_co), 32'h1);
        step(0, 0, 0, 1, 0);

        // Backpressure: result held, 7 offered but refused
        feed(2, 2, 2, 2);
        for (int i = 0; i < 5; i++) begin
            step(1, 7, 0, 0, 0);
            check("bp_sum", 32'(out_sum), 32'h8);
        end
        step(1, 7, 0, 1, 0);
        feed(7, 1, 1, 1);
        check("bp_next_full", 32'(out_full), 32'h0A);
        step(0, 0, 0, 1, 0);

        // Flush mid-collection
        step(1, 9, 0, 1, 0);
        step(1, 9, 0, 1, 0);
        step(1, 9, 1, 1, 0);
        feed(4, 4, 4, 4);
        check("flush_full", 32'(out_full), 32'h10);
        check("flush_sum", 32'(out_sum), 32'h0);
        check("flush_co", 32'(out_co), 32'h1);
        step(0, 0, 0, 1, 0);
        check("flush_rescnt", 32'(res_cnt), 32'h5);

        // Flush while holding a result
        feed(1, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("flushd_valid", 32'(out_valid), 32'h0);
        check("flushd_rescnt", 32'(res_cnt), 32'h5);

        // Reset mid-operation
        step(1, 3, 0, 1, 0);
        step(1, 3, 0, 1, 0);
        step(1, 3, 0, 1, 0);
        step(1, 3, 0, 1, 1);
        check("rst_mid_full", 32'(out_full), 32'h0);
        check("rst_mid_valid", 32'(out_valid), 32'h0);
        feed(1, 1, 1, 1);
        check("rst_mid_sum", 32'(out_full), 32'h4);
        step(0, 0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 4) != 0, int'($urandom % 16),
                 ($urandom % 25) == 0, ($urandom % 3) != 0,
                 ($urandom % 200) == 0);
        end

        // Counter wrap
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 256 * 5; i++) step(1, 0, 0, 1, 0);
        check("wrap_256", 32'(res_cnt), 32'h0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0);
        check("wrap_257", 32'(res_cnt), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
